// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS mult/multu/div/divu sequencer driving HI/LO.
// One shift-add or restoring-divide step per cycle over WIDTH cycles.
// Signed operations run on magnitudes; the result sign is applied at the end.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic             is_div_r;
  logic             neg_r;     // product / quotient sign
  logic             rneg_r;    // remainder sign
  logic [ACC_W-1:0] acc;       // product accumulator
  logic [ACC_W-1:0] mcand;     // shifted multiplicand, or divisor in the low half
  logic [WIDTH-1:0] shreg;     // multiplier, or dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] rem;       // partial remainder, always below the divisor

  logic start_ok, dz, finish;

  // Operand decode for a new request
  logic             op_signed, op_div;
  logic [WIDTH-1:0] mag1, mag2;

  // One iteration step and final sign correction
  logic [ACC_W-1:0] acc_step, prod_fix;
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: abort beats start; divide-by-zero skips RUN
  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    dz       = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start && !abort) begin
          start_ok = 1'b1;
          if (op[1] && (op2 == '0)) begin
            dz       = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand magnitudes and the current iteration's arithmetic
  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    mag1      = (op_signed && op1[WIDTH-1]) ? -op1 : op1;
    mag2      = (op_signed && op2[WIDTH-1]) ? -op2 : op2;

    acc_step  = acc + (shreg[0] ? mcand : '0);
    prod_fix  = neg_r ? -acc_step : acc_step;

    // Extra top bit keeps the trial subtract from wrapping
    rem_sh    = {rem, shreg[WIDTH-1]};
    trial     = rem_sh - {1'b0, mcand[WIDTH-1:0]};
    q_bit     = ~trial[WIDTH];
    rem_step  = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step  = {shreg[WIDTH-2:0], q_bit};
    quo_fix   = neg_r  ? -quo_step : quo_step;
    rem_fix   = rneg_r ? -rem_step : rem_step;
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      is_div_r <= 1'b0;
      neg_r    <= 1'b0;
      rneg_r   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      shreg    <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy <= (state_nx == RUN);
      done <= dz | finish;
      if (start_ok) begin
        cnt      <= '0;
        is_div_r <= op_div;
        neg_r    <= op_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
        rneg_r   <= op_signed & op1[WIDTH-1];
        acc      <= '0;
        rem      <= '0;
        mcand    <= ACC_W'(op_div ? mag2 : mag1);
        shreg    <= op_div ? mag1 : mag2;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        if (is_div_r) begin
          rem   <= rem_step;
          shreg <= quo_step;
        end else begin
          acc   <= acc_step;
          mcand <= mcand << 1;
          shreg <= shreg >> 1;
        end
      end
      if (dz) begin
        hi       <= op1;
        lo       <= '1;
        div_zero <= 1'b1;
      end else if (finish) begin
        div_zero <= 1'b0;
        if (is_div_r) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[ACC_W-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer in the EX stage, alongside the single-cycle ALU. Executes MIPS mult, multu, div and divu over 32 cycles using a shift-add or restoring-divide loop, and drives HI/LO result registers. Gives the pipeline a busy indication for stalling mfhi/mflo and dependent mul/div instructions. Handles divide-by-zero explicitly and flags it, so no result is ever left undefined.

## Interface
- WIDTH, 32: operand width; the iteration count equals WIDTH.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  request; sampled only when state is IDLE or DONE.
- op  in  2  0 = MULT (signed), 1 = MULTU, 2 = DIV (signed), 3 = DIVU.
- op1  in  32  rs value: multiplicand or dividend.
- op2  in  32  rt value: multiplier or divisor.
- abort  in  1  pipeline flush; cancels the operation in flight.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; hi/lo were updated this cycle.
- div_zero  out  1  valid with done; high for DIV/DIVU with op2 == 0.
- hi  out  32  product[63:32] or remainder; registered.
- lo  out  32  product[31:0] or quotient; registered.

## Operation
- **States:** IDLE, RUN, DONE. Reset puts the block in IDLE with busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0 and the counter at 0.
- **Start in IDLE or DONE:**
  - Capture the operation and operand magnitudes (absolute value for signed ops).
  - Capture result-sign flags:
    - Product sign = sign(op1) XOR sign(op2).
    - Quotient sign = sign(op1) XOR sign(op2).
    - Remainder sign = sign(op1).
  - Clear the 64-bit working accumulator and the counter, then go to RUN.
- **Divide by zero:** if op is DIV/DIVU and op2 == 0, go directly to DONE. Set hi = op1, lo = 32'hFFFFFFFF, div_zero = 1.
- **RUN, multiply:** one shift-add step per cycle, LSB of the multiplier first. Accumulator width is 64 bits.
- **RUN, divide:** one restoring step per cycle, MSB of the dividend first. Remainder register is 33 bits so the trial subtract never overflows.
- **End of RUN:** after WIDTH iterations (counter == WIDTH-1 on the final step), move to DONE.
  - Apply sign correction using two's-complement negation.
  - Signed results are 64-bit negate of the product, and independent negate of quotient and remainder.
  - Load hi/lo.
- **DONE:**
  - done = 1 for exactly one cycle; hi/lo hold until the next completion.
  - With start = 1, go back to RUN (back-to-back issue). Otherwise go to IDLE.
- **start during RUN:** ignored; no queuing.
- **abort:**
  - In RUN: go to IDLE next edge. No done pulse; hi/lo keep their previous values.
  - In IDLE or DONE: no effect, and it overrides a simultaneous start.
- **Overflow:** -2^31 / -1 (DIV) gives lo = 32'h80000000, hi = 0. This falls out of magnitude arithmetic and needs no special case.
- **div_zero:** cleared on every done that is not a divide-by-zero.
- **Priority:** reset > abort > start.

## Timing
- start sampled high at the edge closing cycle c:
  - busy = 1 in cycles c+1 through c+32.
  - done = 1 and new hi/lo visible in cycle c+33.
  - Total latency is WIDTH+1 cycles.
- Divide-by-zero start in cycle c: busy stays 0, and done, div_zero, hi and lo are valid in cycle c+1.
- Back-to-back: a start in the DONE cycle c+33 makes busy go high in c+34. The next done is in c+66.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset in the middle of RUN: IDLE at the next edge, all outputs 0, no done pulse.

## Test plan
- **MULT:** op1 = -3, op2 = 5, start in cycle c -> done only in c+33, hi = FFFFFFFF, lo = FFFFFFF1, busy high exactly 32 cycles.
- **MULTU:** op1 = FFFFFFFF, op2 = FFFFFFFF -> hi = FFFFFFFE, lo = 00000001.
- **DIVU then DIV:**
  - DIVU 100/7 -> lo = 14, hi = 2.
  - Back-to-back DIV -7/2 issued in the DONE cycle -> lo = FFFFFFFD, hi = FFFFFFFF. Second done exactly 33 cycles after the first.
- **Edge cases:**
  - DIV 5/0 -> done one cycle after start, div_zero = 1, hi = 5, lo = FFFFFFFF, busy never high.
  - DIV 80000000/FFFFFFFF -> lo = 80000000, hi = 0, div_zero = 0.
- **Interruptions:**
  - start pulsed at RUN cycle 10 -> ignored; result is that of the first op.
  - abort at RUN cycle 5 -> IDLE, no done, hi/lo unchanged.
  - reset at RUN cycle 20 -> all outputs 0 next cycle.
